// File: rtl/cam_sccb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_sccb_pkg
// Description : Shared types and constants for the OV2640 SCCB init master.
//               Holds the FSM state encoding, the init table length, the
//               soft-reset register/bit, and the write retry limit.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_sccb_pkg;

    typedef enum logic [3:0] {
        ST_PWR_WAIT = 4'd0,
        ST_START    = 4'd1,
        ST_BIT      = 4'd2,
        ST_STOP     = 4'd3,
        ST_GAP      = 4'd4,
        ST_NEXT     = 4'd5,
        ST_DONE     = 4'd6,
        ST_IDLE     = 4'd7
    } sccb_state_t;

    localparam int         CAM_INIT_LEN = 23;

    localparam logic [7:0] SOFT_RST_REG = 8'h12;
    localparam int         SOFT_RST_BIT = 7;

    // Total attempts allowed for one table entry before giving up.
    localparam logic [1:0] RETRY_LIMIT  = 2'd3;

    // True when the {reg, val} entry resets the sensor and therefore needs
    // a fresh power-up settle before the next write.
    function automatic logic is_soft_reset(input logic [15:0] entry);
        return (entry[15:8] == SOFT_RST_REG) && entry[SOFT_RST_BIT];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_sccb_init_rom.sv
`default_nettype none
// ============================================================================
// Module      : cam_init_rom
// Description : Combinational OV2640 init table, QVGA RGB565 setup.
//               Each entry is {register address, value}.
// Ports       : addr  - table index (reg_idx of the master)
//               entry - {reg[7:0], val[7:0]}
// Revision    : 1.0 - initial release
// ============================================================================
module cam_init_rom
    import cam_sccb_pkg::*;
(
    input  logic [7:0]  addr,
    output logic [15:0] entry
);

    always_comb begin
        entry = 16'hFF00;
        case (addr)
            8'd0:  entry = {8'hFF, 8'h01};  // bank select: sensor
            8'd1:  entry = {8'h12, 8'h80};  // COM7 soft reset
            8'd2:  entry = {8'hFF, 8'h00};  // bank select: DSP
            8'd3:  entry = {8'h2C, 8'hFF};
            8'd4:  entry = {8'h2E, 8'hDF};
            8'd5:  entry = {8'hFF, 8'h01};  // bank select: sensor
            8'd6:  entry = {8'h3C, 8'h32};
            8'd7:  entry = {8'h11, 8'h00};  // CLKRC: no prescale
            8'd8:  entry = {8'h09, 8'h02};  // COM2: output drive 2x
            8'd9:  entry = {8'h04, 8'h28};
            8'd10: entry = {8'h13, 8'hE5};  // COM8: AGC/AEC on
            8'd11: entry = {8'h14, 8'h48};  // COM9: gain ceiling
            8'd12: entry = {8'h15, 8'h00};
            8'd13: entry = {8'hFF, 8'h00};  // bank select: DSP
            8'd14: entry = {8'hE0, 8'h04};  // hold DVP in reset
            8'd15: entry = {8'hC0, 8'h64};  // HSIZE8
            8'd16: entry = {8'hC1, 8'h4B};  // VSIZE8
            8'd17: entry = {8'hDA, 8'h08};  // IMAGE_MODE: RGB565
            8'd18: entry = {8'hD7, 8'h03};
            8'd19: entry = {8'hE1, 8'h77};
            8'd20: entry = {8'h5A, 8'h50};  // ZMOW: 320/4
            8'd21: entry = {8'h5B, 8'h3C};  // ZMOH: 240/4
            8'd22: entry = {8'hE0, 8'h00};  // release DVP reset
            default: entry = 16'hFF00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cam_sccb_init.sv
`default_nettype none
// ============================================================================
// Module      : cam_sccb_init
// Description : SCCB write master that streams the OV2640 init table after
//               reset. Each entry is a 3-phase write (DEV_ADDR, reg, val),
//               9 bits per phase, 4 quarters per bit.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               start         - re-run the table from IDLE/DONE
//               siod_i        - SIOD pad input (ACK sampling)
//               sioc, siod_oe - SCCB clock, SIOD pull-low enable
//               busy, done, err, reg_idx - status
// Options     : SCCB_ACK_CHECK_EN - sample ACK, abort/retry failed writes.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_sccb_init
    import cam_sccb_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned SCL_HZ         = 100_000,
    parameter logic [7:0]  DEV_ADDR       = 8'h60,
    parameter int unsigned POWERUP_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       siod_i,
    output logic       sioc,
    output logic       siod_oe,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] reg_idx
);

    localparam int unsigned     c_QDIV    = CLK_HZ / (4 * SCL_HZ);
    localparam int              c_QW      = (c_QDIV > 1) ? $clog2(c_QDIV) : 1;
    localparam logic [c_QW-1:0] c_QMAX    = c_QW'(c_QDIV - 1);
    localparam logic [31:0]     c_PWR_MAX = 32'(POWERUP_CYCLES - 1);
    localparam logic [7:0]      c_LAST    = 8'(CAM_INIT_LEN - 1);

    sccb_state_t     r_state, w_state_n;
    logic [c_QW-1:0] r_qcnt, w_qcnt_n, w_qstep;
    logic [1:0]      r_qtr, w_qtr_n;
    logic [3:0]      r_bit, w_bit_n;
    logic [1:0]      r_phase, w_phase_n;
    logic [31:0]     r_pwr_cnt, w_pwr_cnt_n;
    logic [7:0]      r_reg_idx, w_reg_idx_n;
    logic            r_sioc, w_sioc_n;
    logic            r_siod_oe, w_siod_oe_n;
    logic            r_busy, w_busy_n;
    logic            r_done, w_done_n;
    logic            r_err, w_err_n;
    logic            r_nack, w_nack_n;
    logic [1:0]      r_tries, w_tries_n;
    logic [15:0]     w_entry;
    logic            w_wrap;
    logic            w_ack_bad;

    cam_init_rom u_rom (
        .addr  (r_reg_idx),
        .entry (w_entry)
    );

    assign w_wrap  = (r_qcnt == c_QMAX);
    assign w_qstep = w_wrap ? '0 : r_qcnt + 1'b1;

`ifdef SCCB_ACK_CHECK_EN
    assign w_ack_bad = siod_i;
`else
    logic w_unused_siod;
    assign w_unused_siod = siod_i;
    assign w_ack_bad     = 1'b0;
`endif

    // SIOD pull-low enable for bit b of phase ph; the 9th bit is released.
    function automatic logic data_oe(input logic [15:0] entry,
                                     input logic [1:0]  ph,
                                     input logic [3:0]  b);
        logic [7:0] byte_v;
        case (ph)
            2'd0:    byte_v = DEV_ADDR;
            2'd1:    byte_v = entry[15:8];
            default: byte_v = entry[7:0];
        endcase
        if (b >= 4'd8) return 1'b0;
        return ~byte_v[3'd7 - b[2:0]];
    endfunction

    always_comb begin
        w_state_n   = r_state;
        w_qcnt_n    = '0;
        w_qtr_n     = r_qtr;
        w_bit_n     = r_bit;
        w_phase_n   = r_phase;
        w_pwr_cnt_n = r_pwr_cnt;
        w_reg_idx_n = r_reg_idx;
        w_sioc_n    = r_sioc;
        w_siod_oe_n = r_siod_oe;
        w_busy_n    = r_busy;
        w_done_n    = r_done;
        w_err_n     = r_err;
        w_nack_n    = r_nack;
        w_tries_n   = r_tries;

        case (r_state)
            ST_PWR_WAIT: begin
                w_busy_n    = 1'b1;
                w_sioc_n    = 1'b1;
                w_siod_oe_n = 1'b0;
                if (r_pwr_cnt == c_PWR_MAX) begin
                    w_pwr_cnt_n = '0;
                    w_qtr_n     = 2'd0;
                    w_state_n   = ST_START;
                end else begin
                    w_pwr_cnt_n = r_pwr_cnt + 32'd1;
                end
            end

            // q0: SIOD released, SCL high. q1: SIOD low (start condition).
            ST_START: begin
                w_qcnt_n = w_qstep;
                w_nack_n = 1'b0;
                if (w_wrap) begin
                    if (r_qtr == 2'd0) begin
                        w_qtr_n     = 2'd1;
                        w_siod_oe_n = 1'b1;
                    end else begin
                        w_state_n   = ST_BIT;
                        w_qtr_n     = 2'd0;
                        w_phase_n   = 2'd0;
                        w_bit_n     = 4'd0;
                        w_sioc_n    = 1'b0;
                        w_siod_oe_n = data_oe(w_entry, 2'd0, 4'd0);
                    end
                end
            end

            // Outputs for quarter n+1 are loaded on the wrap of quarter n.
            ST_BIT: begin
                w_qcnt_n = w_qstep;
                if (w_wrap) begin
                    w_qtr_n = r_qtr + 2'd1;
                    case (r_qtr)
                        2'd0: w_sioc_n = 1'b1;
                        2'd1: w_sioc_n = 1'b1;
                        2'd2: begin
                            w_sioc_n = 1'b0;
                            if (r_bit == 4'd8 && w_ack_bad) w_nack_n = 1'b1;
                        end
                        default: begin
                            w_qtr_n = 2'd0;
                            if (r_bit != 4'd8) begin
                                w_bit_n     = r_bit + 4'd1;
                                w_siod_oe_n = data_oe(w_entry, r_phase, r_bit + 4'd1);
                            end else if (r_phase != 2'd2 && !r_nack) begin
                                w_phase_n   = r_phase + 2'd1;
                                w_bit_n     = 4'd0;
                                w_siod_oe_n = data_oe(w_entry, r_phase + 2'd1, 4'd0);
                            end else begin
                                w_state_n   = ST_STOP;
                                w_sioc_n    = 1'b1;
                                w_siod_oe_n = 1'b1;
                            end
                        end
                    endcase
                end
            end

            // q0: SIOD low with SCL high. q1: SIOD released (stop condition).
            ST_STOP: begin
                w_qcnt_n = w_qstep;
                if (w_wrap) begin
                    if (r_qtr == 2'd0) begin
                        w_qtr_n     = 2'd1;
                        w_siod_oe_n = 1'b0;
                    end else begin
                        w_qtr_n   = 2'd0;
                        w_state_n = ST_GAP;
                    end
                end
            end

            ST_GAP: begin
                w_qcnt_n = w_qstep;
                if (w_wrap) begin
                    w_qtr_n = r_qtr + 2'd1;
                    if (r_qtr == 2'd3) begin
                        w_qtr_n   = 2'd0;
                        w_state_n = ST_NEXT;
                    end
                end
            end

            ST_NEXT: begin
                w_qtr_n = 2'd0;
                if (r_nack) begin
                    if (r_tries == RETRY_LIMIT - 2'd1) begin
                        w_tries_n = 2'd0;
                        w_err_n   = 1'b1;
                        w_busy_n  = 1'b0;
                        w_state_n = ST_IDLE;
                    end else begin
                        w_tries_n = r_tries + 2'd1;
                        w_state_n = ST_START;
                    end
                end else if (r_reg_idx == c_LAST) begin
                    w_tries_n = 2'd0;
                    w_busy_n  = 1'b0;
                    w_done_n  = 1'b1;
                    w_state_n = ST_DONE;
                end else begin
                    w_tries_n   = 2'd0;
                    w_reg_idx_n = r_reg_idx + 8'd1;
                    w_pwr_cnt_n = '0;
                    w_state_n   = is_soft_reset(w_entry) ? ST_PWR_WAIT : ST_START;
                end
            end

            ST_DONE, ST_IDLE: begin
                if (start) begin
                    w_done_n    = 1'b0;
                    w_err_n     = 1'b0;
                    w_busy_n    = 1'b1;
                    w_reg_idx_n = 8'd0;
                    w_tries_n   = 2'd0;
                    w_qtr_n     = 2'd0;
                    w_state_n   = ST_START;
                end
            end

            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_PWR_WAIT;
            r_qcnt    <= '0;
            r_qtr     <= 2'd0;
            r_bit     <= 4'd0;
            r_phase   <= 2'd0;
            r_pwr_cnt <= '0;
            r_reg_idx <= 8'd0;
            r_sioc    <= 1'b1;
            r_siod_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_nack    <= 1'b0;
            r_tries   <= 2'd0;
        end else begin
            r_state   <= w_state_n;
            r_qcnt    <= w_qcnt_n;
            r_qtr     <= w_qtr_n;
            r_bit     <= w_bit_n;
            r_phase   <= w_phase_n;
            r_pwr_cnt <= w_pwr_cnt_n;
            r_reg_idx <= w_reg_idx_n;
            r_sioc    <= w_sioc_n;
            r_siod_oe <= w_siod_oe_n;
            r_busy    <= w_busy_n;
            r_done    <= w_done_n;
            r_err     <= w_err_n;
            r_nack    <= w_nack_n;
            r_tries   <= w_tries_n;
        end
    end

    assign sioc    = r_sioc;
    assign siod_oe = r_siod_oe;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign reg_idx = r_reg_idx;

endmodule
`default_nettype wire

// File: tb/tb_cam_sccb_init.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_sccb_init
// Description : Self-checking bench for cam_sccb_init with QDIV=1 and a
//               16-cycle power-up wait. A bus monitor decodes SCCB writes
//               from sioc/siod_oe; decoded writes are compared against a
//               table of hand-written expected entries.
// Options     : SCCB_ACK_CHECK_EN - selects the ACK-failure expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_sccb_init;
    import cam_sccb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       siod_i;
    logic       sioc;
    logic       siod_oe;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] reg_idx;

    cam_sccb_init #(
        .CLK_HZ         (4_000_000),
        .SCL_HZ         (1_000_000),
        .DEV_ADDR       (8'h60),
        .POWERUP_CYCLES (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .siod_i  (siod_i),
        .sioc    (sioc),
        .siod_oe (siod_oe),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .reg_idx (reg_idx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- bus monitor ----------------
    typedef struct {
        logic [26:0] bits;
        int          nbits;
        int          start_cyc;
        int          stop_cyc;
    } tx_t;

    tx_t  txq[$];
    tx_t  cur;
    int   cyc       = 0;
    logic prev_sioc = 1'b1;
    logic prev_oe   = 1'b0;
    bit   in_tx     = 0;
    bit   pend      = 0;
    logic pend_bit  = 1'b0;

    // A bit is latched on SCL rise and committed on the following SCL fall;
    // the SCL rise that opens a stop condition has no fall and is dropped.
    always @(negedge clk) begin
        cyc++;
        if (prev_sioc && sioc && !prev_oe && siod_oe) begin
            cur.bits      = '0;
            cur.nbits     = 0;
            cur.start_cyc = cyc;
            cur.stop_cyc  = 0;
            in_tx         = 1;
            pend          = 0;
        end else if (prev_sioc && sioc && prev_oe && !siod_oe) begin
            if (in_tx) begin
                cur.stop_cyc = cyc;
                txq.push_back(cur);
            end
            in_tx = 0;
            pend  = 0;
        end else if (!prev_sioc && sioc) begin
            pend     = 1;
            pend_bit = ~siod_oe;
        end else if (prev_sioc && !sioc && pend && in_tx) begin
            if (cur.nbits < 27) begin
                cur.bits = {cur.bits[25:0], pend_bit};
                cur.nbits++;
            end
            pend = 0;
        end
        prev_sioc = sioc;
        prev_oe   = siod_oe;
    end

    // ---------------- helpers ----------------
    task automatic first_fall(input string tag);
        int  at;
        bit  sioc_moved;
        at         = 0;
        sioc_moved = 0;
        for (int i = 1; i <= 40 && at == 0; i++) begin
            @(negedge clk);
            if (i == 1) check({tag, "_busy_in_pwr_wait"}, busy, 1);
            if (siod_oe) at = i;
            else if (!sioc) sioc_moved = 1;
        end
        // 16 power-up cycles, then one START quarter with SIOD released.
        check({tag, "_first_siod_fall_cycle"}, at, 17);
        check({tag, "_sioc_quiet_before_start"}, sioc_moved, 0);
    endtask

    task automatic wait_reg_idx(input logic [7:0] target, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (reg_idx == target) ok = 1;
        end
    endtask

    typedef struct {
        int         tx;
        logic [7:0] reg_a;
        logic [7:0] val;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int  base;
        int  idle01;
        int  idle12;
        bit  ok;
        bit  busy_before;
        tx_t t;

        vecs[0].tx = 0;  vecs[0].reg_a = 8'hFF; vecs[0].val = 8'h01;
        vecs[1].tx = 1;  vecs[1].reg_a = 8'h12; vecs[1].val = 8'h80;
        vecs[2].tx = 2;  vecs[2].reg_a = 8'hFF; vecs[2].val = 8'h00;
        vecs[3].tx = 3;  vecs[3].reg_a = 8'h2C; vecs[3].val = 8'hFF;
        vecs[4].tx = 22; vecs[4].reg_a = 8'hE0; vecs[4].val = 8'h00;

        rst    = 1'b1;
        start  = 1'b0;
        siod_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sioc",    sioc,    1);
        check("rst_siod_oe", siod_oe, 0);
        check("rst_busy",    busy,    0);
        check("rst_done",    done,    0);
        check("rst_err",     err,     0);
        check("rst_reg_idx", reg_idx, 0);

        // ---------------- full run from reset ----------------
        base = txq.size();
        rst  = 1'b0;
        first_fall("boot");

        ok          = 0;
        busy_before = 0;
        for (int i = 0; i < 10000 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1;
            else busy_before = busy;
        end
        check("run_done_timeout", ok, 1);
        check("run_busy_low_with_done", busy, 0);
        check("run_busy_high_before_done", busy_before, 1);
        check("run_err", err, 0);
        check("run_tx_count", txq.size() - base, CAM_INIT_LEN);

        if (txq.size() - base == CAM_INIT_LEN) begin
            for (int v = 0; v < 5; v++) begin
                t = txq[base + vecs[v].tx];
                check($sformatf("tx%0d_nbits", vecs[v].tx), t.nbits, 27);
                check($sformatf("tx%0d_dev", vecs[v].tx), t.bits[26:19], 8'h60);
                check($sformatf("tx%0d_reg", vecs[v].tx), t.bits[17:10], vecs[v].reg_a);
                check($sformatf("tx%0d_val", vecs[v].tx), t.bits[8:1], vecs[v].val);
                check($sformatf("tx%0d_ack_released", vecs[v].tx),
                      {t.bits[18], t.bits[9], t.bits[0]}, 3'b111);
            end
            idle01 = txq[base + 1].start_cyc - txq[base].stop_cyc;
            idle12 = txq[base + 2].start_cyc - txq[base + 1].stop_cyc;
            check("gap_after_soft_reset_ge16", idle12 >= 16, 1);
            check("gap_plain_below16", idle01 < 16, 1);
        end

        // ---------------- restart with start pulse ----------------
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_done_cleared", done, 0);
        check("restart_busy", busy, 1);
        check("restart_reg_idx", reg_idx, 0);
        check("restart_siod_released", siod_oe, 0);
        @(negedge clk);
        check("restart_siod_fall_after_qdiv", siod_oe, 1);

        // ---------------- reset in the middle of transaction 3 ----------------
        wait_reg_idx(8'd3, 3000, ok);
        check("reach_tx3_timeout", ok, 1);
        repeat (12) @(negedge clk);
        check("tx3_in_progress", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sioc", sioc, 1);
        check("midrst_siod_oe", siod_oe, 0);
        check("midrst_done", done, 0);
        check("midrst_reg_idx", reg_idx, 0);
        base = txq.size();
        rst  = 1'b0;
        first_fall("after_rst");
        ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (txq.size() > base) ok = 1;
        end
        check("after_rst_tx_timeout", ok, 1);
        if (ok) begin
            t = txq[base];
            check("after_rst_tx_reg", t.bits[17:10], 8'hFF);
            check("after_rst_tx_val", t.bits[8:1], 8'h01);
        end

        // ---------------- NACK handling (siod_i held high) ----------------
        rst    = 1'b1;
        siod_i = 1'b1;
        repeat (2) @(negedge clk);
        base = txq.size();
        rst  = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (err) ok = 1;
        end
        check("nack_err_timeout", ok, 1);
        check("nack_busy", busy, 0);
        check("nack_done", done, 0);
        check("nack_reg_idx", reg_idx, 0);
        check("nack_attempts", txq.size() - base, 3);
        for (int a = 0; a < 3 && base + a < txq.size(); a++) begin
            t = txq[base + a];
            check($sformatf("nack_try%0d_nbits", a), t.nbits, 9);
            check($sformatf("nack_try%0d_dev", a), t.bits[8:1], 8'h60);
        end
        repeat (20) @(negedge clk);
        check("nack_parked_busy", busy, 0);
        check("nack_parked_err", err, 1);
`else
        wait_reg_idx(8'd2, 3000, ok);
        check("ack_ignored_progress", ok, 1);
        check("ack_ignored_err", err, 0);
        if (txq.size() > base) begin
            t = txq[base];
            check("ack_ignored_tx0_nbits", t.nbits, 27);
        end else begin
            check("ack_ignored_tx0_seen", 0, 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
